// File: rtl/addsub_arbiter.sv
// addsub_arbiter: two requesters share one add/subtract datapath.
// The datapath holds one result at a time, in an IDLE/RESP handshake.
// Optional macro ARB_ROUND_ROBIN_EN: ties go to the requester not granted most recently.
// When the macro is not defined, ties always go to requester 0.
module addsub_arbiter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_m,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_m,
  output logic             req1_ready,
  output logic             rsp_valid,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_s,
  output logic             rsp_c,
  input  logic             rsp_ready
);

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_t;

  state_t           state;
  logic             gnt_en;
  logic             gnt_id;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic             sel_m;
  logic [WIDTH:0]   sum;

`ifdef ARB_ROUND_ROBIN_EN
  logic prio;

  // Tie-break pointer: after a grant, the other requester wins the next tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      prio <= 1'b0;
    end else if (gnt_en) begin
      prio <= ~gnt_id;
    end
  end
`endif

  // Select the winning requester among the valid ones.
  always_comb begin
    gnt_id = 1'b0;
    if (req0_valid && req1_valid) begin
`ifdef ARB_ROUND_ROBIN_EN
      gnt_id = prio;
`else
      gnt_id = 1'b0;
`endif
    end else if (req1_valid) begin
      gnt_id = 1'b1;
    end
  end

  // A grant happens only in IDLE, outside reset, and only when a request is present.
  assign gnt_en     = !rst && (state == IDLE) && (req0_valid || req1_valid);
  assign req0_ready = gnt_en && !gnt_id;
  assign req1_ready = gnt_en && gnt_id;

  // Shared datapath. Subtraction is computed as a + ~b + 1.
  // The carry out of a + ~b + 1 is the no-borrow flag.
  always_comb begin
    sel_a = gnt_id ? req1_a : req0_a;
    sel_b = gnt_id ? req1_b : req0_b;
    sel_m = gnt_id ? req1_m : req0_m;
    sum   = {1'b0, sel_a} + {1'b0, (sel_m ? ~sel_b : sel_b)} + (WIDTH+1)'(sel_m);
  end

  // Handshake FSM. The response registers load on the grant edge.
  // They hold their value until the consumer takes the result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_s     <= '0;
      rsp_c     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt_en) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_id    <= gnt_id;
            rsp_s     <= sum[WIDTH-1:0];
            rsp_c     <= sum[WIDTH];
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_addsub_arbiter.sv
// tb_addsub_arbiter: directed and random checks of addsub_arbiter.
// The reference model is written from the arithmetic and arbitration rules.
module tb_addsub_arbiter;

  localparam int unsigned WIDTH = 4;
  localparam int MODV = 1 << WIDTH;
`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             req0_valid, req1_valid;
  logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
  logic             req0_m, req1_m;
  logic             req0_ready, req1_ready;
  logic             rsp_valid, rsp_id, rsp_c, rsp_ready;
  logic [WIDTH-1:0] rsp_s;

  int errors = 0;
  int checks = 0;
  int last_gnt = 1;  // requester granted most recently; 1 means requester 0 wins the next tie

  addsub_arbiter #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_m(req0_m), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_m(req1_m), .req1_ready(req1_ready),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_s(rsp_s), .rsp_c(rsp_c), .rsp_ready(rsp_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Expected {c,s}: c is the carry for add and a>=b for subtract.
  function automatic logic [WIDTH:0] ref_op(input int a, input int b, input bit m);
    int t;
    int s;
    bit c;
    if (!m) begin
      t = a + b;
      c = (t >= MODV);
    end else begin
      t = a - b;
      c = (a >= b);
    end
    s = ((t % MODV) + MODV) % MODV;
    return {c, s[WIDTH-1:0]};
  endfunction

  function automatic int winner(input bit v0, input bit v1);
    if (v0 && v1) return RR ? (1 - last_gnt) : 0;
    return v1 ? 1 : 0;
  endfunction

  task automatic randomize_ops();
    req0_a = WIDTH'($urandom); req0_b = WIDTH'($urandom); req0_m = 1'($urandom);
    req1_a = WIDTH'($urandom); req1_b = WIDTH'($urandom); req1_m = 1'($urandom);
  endtask

  task automatic check_rsp(input string tag, input int id, input logic [WIDTH:0] e);
    check({tag, "_valid"}, rsp_valid, 1);
    check({tag, "_id"}, rsp_id, id);
    check({tag, "_s"}, rsp_s, e[WIDTH-1:0]);
    check({tag, "_c"}, rsp_c, e[WIDTH]);
  endtask

  // One single-requester operation with an always-ready consumer.
  task automatic do_op(input string tag, input int id, input int a, input int b, input bit m);
    logic [WIDTH:0] e;
    @(negedge clk);
    randomize_ops();
    rsp_ready  = 1'b1;
    req0_valid = (id == 0);
    req1_valid = (id == 1);
    if (id == 0) begin req0_a = WIDTH'(a); req0_b = WIDTH'(b); req0_m = m; end
    else         begin req1_a = WIDTH'(a); req1_b = WIDTH'(b); req1_m = m; end
    #1;
    check({tag, "_rdy0"}, req0_ready, (id == 0));
    check({tag, "_rdy1"}, req1_ready, (id == 1));
    e = ref_op(a, b, m);
    last_gnt = id;
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    randomize_ops();
    check_rsp(tag, id, e);
    @(negedge clk);
    check({tag, "_done"}, rsp_valid, 0);
  endtask

  initial begin
    logic [WIDTH:0] e;
    int w;
    int hid;
    logic [WIDTH-1:0] hs;
    logic hc;

    // Reset: the readies stay low even with requests present.
    rst = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b0;
    randomize_ops();
    @(negedge clk); #1;
    check("rst_rdy0", req0_ready, 0);
    check("rst_rdy1", req1_ready, 0);
    @(negedge clk);
    check("rst_valid", rsp_valid, 0);
    check("rst_id", rsp_id, 0);
    check("rst_s", rsp_s, 0);
    check("rst_c", rsp_c, 0);
    rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
    @(negedge clk); #1;
    check("idle_rdy0", req0_ready, 0);
    check("idle_rdy1", req1_ready, 0);
    check("idle_valid", rsp_valid, 0);

    // Directed arithmetic cases.
    do_op("add_3_5", 0, 3, 5, 1'b0);
    do_op("add_9_9", 1, 9, 9, 1'b0);
    do_op("sub_5_3", 1, 5, 3, 1'b1);
    do_op("sub_3_5", 0, 3, 5, 1'b1);
    do_op("add_max", 0, MODV - 1, MODV - 1, 1'b0);
    do_op("sub_eq", 1, 7, 7, 1'b1);

    // Random single-requester operations.
    for (int i = 0; i < 16; i++)
      do_op("rand", int'($urandom_range(0, 1)), int'($urandom_range(0, MODV - 1)),
            int'($urandom_range(0, MODV - 1)), 1'($urandom));

    // Both requesters valid with an always-ready consumer: one grant every 2 cycles.
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
      randomize_ops();
      #1;
      w = winner(1'b1, 1'b1);
      check("tie_rdy0", req0_ready, (w == 0));
      check("tie_rdy1", req1_ready, (w == 1));
      e = (w == 0) ? ref_op(int'(req0_a), int'(req0_b), req0_m) : ref_op(int'(req1_a), int'(req1_b), req1_m);
      last_gnt = w;
      @(negedge clk);
      randomize_ops();
      #1;
      check("tie_busy_rdy0", req0_ready, 0);
      check("tie_busy_rdy1", req1_ready, 0);
      check_rsp("tie", w, e);
    end

    // Consumer stalls for 3 cycles; the held response must not change.
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b1; rsp_ready = 1'b0;
    randomize_ops();
    #1;
    check("stall_rdy1", req1_ready, 1);
    e = ref_op(int'(req1_a), int'(req1_b), req1_m);
    last_gnt = 1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      req0_valid = 1'b1; req1_valid = 1'b1;
      randomize_ops();
      #1;
      check("stall_rdy0", req0_ready, 0);
      check("stall_rdy1", req1_ready, 0);
      check_rsp("stall", 1, e);
    end
    rsp_ready = 1'b1;
    @(negedge clk); #1;
    check("release_valid", rsp_valid, 0);
    w = winner(1'b1, 1'b1);
    check("regrant_rdy0", req0_ready, (w == 0));
    check("regrant_rdy1", req1_ready, (w == 1));
    req0_valid = 1'b0; req1_valid = 1'b0;

    // Reset during RESP discards the result and restores requester-0 tie priority.
    @(negedge clk);
    req0_valid = 1'b1; req0_a = 4'd6; req0_b = 4'd2; req0_m = 1'b0; rsp_ready = 1'b0;
    #1;
    check("pre_rst_rdy0", req0_ready, 1);
    last_gnt = 0;
    @(negedge clk);
    check_rsp("pre_rst", 0, ref_op(6, 2, 1'b0));
    rst = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    check("in_rst_rdy0", req0_ready, 0);
    check("in_rst_rdy1", req1_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    last_gnt = 1;
    #1;
    check("post_rst_valid", rsp_valid, 0);
    check("post_rst_id", rsp_id, 0);
    check("post_rst_s", rsp_s, 0);
    check("post_rst_c", rsp_c, 0);
    w = winner(1'b1, 1'b1);
    check("post_rst_rdy0", req0_ready, (w == 0));
    check("post_rst_rdy1", req1_ready, (w == 1));
    e = ref_op(int'(req0_a), int'(req0_b), req0_m);
    last_gnt = w;
    hid = w; hs = e[WIDTH-1:0]; hc = e[WIDTH];
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
    check("post_rst_rsp_id", rsp_id, hid);
    check("post_rst_rsp_s", rsp_s, hs);
    check("post_rst_rsp_c", rsp_c, hc);
    @(negedge clk);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
